riscv_v_uop_sequencer: RTL and testbench
========================================

# riscv_v_uop_sequencer

Micro-op sequencer between vector instruction decode and the per-register vector decode/ALU stage. It accepts one vector instruction with its vtype (vsew, integer LMUL), vl and vstart. It splits the instruction into one micro-op per architectural register of the register group. Each micro-op carries the register indices and the per-register active-element window (start, len), which the element decoder turns into valid masks. Micro-ops with no active elements are skipped.

## Interface
Parameters:
- VLEN_BYTES, 16, bytes per vector register (power of two).
- MAX_LMUL_LOG2, 3, largest supported log2(LMUL). Only integer LMUL 1/2/4/8 is supported.
- VL_W, $clog2(VLEN_BYTES*8)+1, width of vl/vstart.
- LEN_W, $clog2(VLEN_BYTES)+1, width of per-uop start/len.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  sequencer can accept an instruction.
- in_vsew  in  3  element width code: 0=8b, 1=16b, 2=32b, 3=64b, 4=128b. Codes 5-7 are illegal.
- in_vlmul  in  2  log2(LMUL), 0..3.
- in_vl  in  VL_W  vector length in elements.
- in_vstart  in  VL_W  first element to execute.
- in_vd, in_vs1, in_vs2  in  5 each  base register indices of the group.
- flush  in  1  kill the in-flight instruction.
- uop_valid  out  1  micro-op valid.
- uop_ready  in  1  downstream accepts micro-op.
- uop_vd, uop_vs1, uop_vs2  out  5 each  base index + uop index, modulo 32.
- uop_vsew  out  3  latched vsew.
- uop_start  out  LEN_W  first active element within this register.
- uop_len  out  LEN_W  elements with index < len are in bounds in this register.
- uop_first, uop_last  out  1  first / last issued micro-op of the instruction.
- done  out  1  one-cycle pulse when the instruction retires.
- illegal  out  1  one-cycle pulse, coincident with done, for illegal vsew.

## Operation
- EPR = VLEN_BYTES >> vsew, the elements per register. NREG = 1 << vlmul. VLMAX = EPR*NREG.
- Effective vl: vl_e = min(in_vl, VLMAX).
- For uop index i with base = i*EPR:
  - uop_len = clamp(vl_e - base, 0, EPR)
  - uop_start = clamp(in_vstart - base, 0, EPR)
- Issue range: i_first = in_vstart / EPR, i_last = ceil(vl_e / EPR) - 1. Indices i_first..i_last are issued in ascending order; all other indices are skipped.
- States:
  - IDLE: in_ready=1.
    - On in_valid with legal vsew and in_vstart < vl_e: latch all fields, set i = i_first, go to ISSUE.
    - On in_valid with in_vstart >= vl_e (including vl=0): stay in IDLE and pulse done next cycle. No uops are issued.
    - On in_valid with illegal vsew: stay in IDLE and pulse done plus illegal next cycle. No uops are issued.
  - ISSUE: in_ready=0, uop_valid=1.
    - On uop_valid&&uop_ready: if i == i_last, go to IDLE and pulse done next cycle; otherwise i++.
- Division and multiplication are by powers of two and are implemented as shifts. There are no dividers.
- flush has priority over every other event. The next cycle is IDLE with uop_valid=0 and no done. An instruction presented in the flush cycle is not accepted.
- rst has the same effect as flush. Reset values: state IDLE; uop_valid, done, illegal, uop_first, uop_last = 0; all uop fields = 0; in_ready=1 in the cycle after reset.

## Timing
- Accept-to-first-uop latency: 1 cycle. uop_valid rises the cycle after the in_valid&&in_ready handshake.
- Sustained throughput: one uop per cycle while uop_ready=1.
- All uop_* outputs are registered. They hold stable while uop_valid && !uop_ready.
- done is asserted the cycle after the last uop handshake or after an empty/illegal accept. in_ready is already 1 in that cycle, so back-to-back instructions lose only one cycle.
- uop_first and uop_last are both 1 for a single-uop instruction.

## Test plan
- VLEN_BYTES=16, vsew=2, vlmul=2, vl=10, vstart=0, vd=8 -> 3 uops:
  - vd=8, start=0, len=4, first=1
  - vd=9, start=0, len=4
  - vd=10, start=0, len=2, last=1
  - Index 11 is skipped; done pulses 1 cycle after the third handshake.
- Same instruction with vstart=5 -> 2 uops:
  - vd=9, start=1, len=4, first=1
  - vd=10, start=0, len=2, last=1
- vl=10, vstart=10 -> no uop_valid, done pulses next cycle, illegal=0. vl=200 with vsew=0, vlmul=3 -> clamped to 128; 8 uops, each len=16.
- uop_ready held low 3 cycles on the second uop -> all uop fields stable for those cycles. Issue resumes in order when ready returns high, with no duplicates or drops.
- vsew=6 -> illegal and done pulse together the next cycle, no uops, in_ready stays 1. Flush asserted while uop 2 of 4 is pending -> uop_valid=0 next cycle, no done, and a new instruction is accepted afterwards.
- Reset asserted mid-ISSUE, plus vd=30 with vlmul=2 -> state returns to IDLE with all outputs 0 after reset. The vd=30 group wraps to uop_vd = 30, 31, 0, 1.

Source files
------------

// File: rtl/riscv_v_uop_sequencer.sv
// Vector micro-op sequencer: splits one vector instruction into per-register
// micro-ops carrying register indices and the active-element window.
module riscv_v_uop_sequencer #(
  parameter int VLEN_BYTES    = 16,
  parameter int MAX_LMUL_LOG2 = 3,
  parameter int VL_W          = $clog2(VLEN_BYTES*8)+1,
  parameter int LEN_W         = $clog2(VLEN_BYTES)+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_vsew,
  input  logic [1:0]       in_vlmul,
  input  logic [VL_W-1:0]  in_vl,
  input  logic [VL_W-1:0]  in_vstart,
  input  logic [4:0]       in_vd,
  input  logic [4:0]       in_vs1,
  input  logic [4:0]       in_vs2,
  input  logic             flush,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [4:0]       uop_vd,
  output logic [4:0]       uop_vs1,
  output logic [4:0]       uop_vs2,
  output logic [2:0]       uop_vsew,
  output logic [LEN_W-1:0] uop_start,
  output logic [LEN_W-1:0] uop_len,
  output logic             uop_first,
  output logic             uop_last,
  output logic             done,
  output logic             illegal
);
  localparam int VB_LOG2 = $clog2(VLEN_BYTES);
  localparam int IDX_W   = MAX_LMUL_LOG2 + 1;

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;

  logic [VL_W-1:0]  r_vle, r_vstart, r_sh;
  logic [4:0]       r_vd, r_vs1, r_vs2;
  logic [IDX_W-1:0] r_idx, r_ilast;

  logic             in_illegal, in_empty;
  logic [VL_W-1:0]  in_sh, in_epr, in_vlmax, in_vle;
  logic [IDX_W-1:0] in_ifirst, in_ilast;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [VL_W-1:0] lim,
                                                 input logic [VL_W-1:0] base,
                                                 input logic [VL_W-1:0] epr);
    logic [VL_W-1:0] d;
    d = (lim > base) ? lim - base : '0;
    if (d > epr) d = epr;
    return LEN_W'(d);
  endfunction

  // All per-register scaling is by powers of two, so EPR is kept as a shift amount.
  always_comb begin
    in_illegal = (in_vsew > 3'd4) || (int'(in_vsew) > VB_LOG2) ||
                 (int'(in_vlmul) > MAX_LMUL_LOG2);
    in_sh      = in_illegal ? '0 : VL_W'(VB_LOG2) - VL_W'(in_vsew);
    in_epr     = VL_W'(1) << in_sh;
    in_vlmax   = in_epr << in_vlmul;
    in_vle     = (in_vl < in_vlmax) ? in_vl : in_vlmax;
    in_ifirst  = IDX_W'(in_vstart >> in_sh);
    in_ilast   = IDX_W'(((in_vle + in_epr - VL_W'(1)) >> in_sh) - VL_W'(1));
    in_empty   = (in_vstart >= in_vle);
  end

  logic [VL_W-1:0]  c_vle, c_vstart, c_sh, c_epr, c_base;
  logic [IDX_W-1:0] c_idx, c_ilast;
  logic [4:0]       c_vd, c_vs1, c_vs2;
  logic [LEN_W-1:0] c_start, c_len;

  // One shared window calculator: first uop from the inputs, later uops from latched state.
  always_comb begin
    if (state == IDLE) begin
      c_vle    = in_vle;
      c_vstart = in_vstart;
      c_sh     = in_sh;
      c_idx    = in_ifirst;
      c_ilast  = in_ilast;
      c_vd     = in_vd;
      c_vs1    = in_vs1;
      c_vs2    = in_vs2;
    end else begin
      c_vle    = r_vle;
      c_vstart = r_vstart;
      c_sh     = r_sh;
      c_idx    = r_idx + IDX_W'(1);
      c_ilast  = r_ilast;
      c_vd     = r_vd;
      c_vs1    = r_vs1;
      c_vs2    = r_vs2;
    end
    c_epr   = VL_W'(1) << c_sh;
    c_base  = VL_W'(c_idx) << c_sh;
    c_len   = clamp_len(c_vle, c_base, c_epr);
    c_start = clamp_len(c_vstart, c_base, c_epr);
  end

  assign in_ready = (state == IDLE) && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      uop_valid <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
      uop_first <= 1'b0;
      uop_last  <= 1'b0;
      uop_vd    <= '0;
      uop_vs1   <= '0;
      uop_vs2   <= '0;
      uop_vsew  <= '0;
      uop_start <= '0;
      uop_len   <= '0;
      r_vle     <= '0;
      r_vstart  <= '0;
      r_sh      <= '0;
      r_vd      <= '0;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_idx     <= '0;
      r_ilast   <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_illegal) begin
              done    <= 1'b1;
              illegal <= 1'b1;
            end else if (in_empty) begin
              done <= 1'b1;
            end else begin
              state     <= ISSUE;
              uop_valid <= 1'b1;
              uop_vsew  <= in_vsew;
              r_vle     <= in_vle;
              r_vstart  <= in_vstart;
              r_sh      <= in_sh;
              r_vd      <= in_vd;
              r_vs1     <= in_vs1;
              r_vs2     <= in_vs2;
              r_idx     <= c_idx;
              r_ilast   <= c_ilast;
              uop_vd    <= c_vd  + 5'(c_idx);
              uop_vs1   <= c_vs1 + 5'(c_idx);
              uop_vs2   <= c_vs2 + 5'(c_idx);
              uop_start <= c_start;
              uop_len   <= c_len;
              uop_first <= 1'b1;
              uop_last  <= (c_idx == c_ilast);
            end
          end
        end
        ISSUE: begin
          if (uop_ready) begin
            if (r_idx == r_ilast) begin
              state     <= IDLE;
              uop_valid <= 1'b0;
              uop_first <= 1'b0;
              uop_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              r_idx     <= c_idx;
              uop_vd    <= c_vd  + 5'(c_idx);
              uop_vs1   <= c_vs1 + 5'(c_idx);
              uop_vs2   <= c_vs2 + 5'(c_idx);
              uop_start <= c_start;
              uop_len   <= c_len;
              uop_first <= 1'b0;
              uop_last  <= (c_idx == c_ilast);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_v_uop_sequencer.sv
// Directed bench for riscv_v_uop_sequencer with hand-computed micro-op tables.
module tb_riscv_v_uop_sequencer;
  localparam int VL_W  = 8;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, flush, uop_valid, uop_ready;
  logic [2:0]       in_vsew, uop_vsew;
  logic [1:0]       in_vlmul;
  logic [VL_W-1:0]  in_vl, in_vstart;
  logic [4:0]       in_vd, in_vs1, in_vs2, uop_vd, uop_vs1, uop_vs2;
  logic [LEN_W-1:0] uop_start, uop_len;
  logic             uop_first, uop_last, done, illegal;

  int checks = 0;
  int errors = 0;

  riscv_v_uop_sequencer #(.VLEN_BYTES(16), .MAX_LMUL_LOG2(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vsew(in_vsew), .in_vlmul(in_vlmul), .in_vl(in_vl), .in_vstart(in_vstart),
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2), .flush(flush),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_vd(uop_vd),
    .uop_vs1(uop_vs1), .uop_vs2(uop_vs2), .uop_vsew(uop_vsew),
    .uop_start(uop_start), .uop_len(uop_len), .uop_first(uop_first),
    .uop_last(uop_last), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] sew, input logic [1:0] lmul,
                         input int vl, input int vstart, input logic [4:0] vd);
    in_valid  = 1'b1;
    in_vsew   = sew;
    in_vlmul  = lmul;
    in_vl     = VL_W'(vl);
    in_vstart = VL_W'(vstart);
    in_vd     = vd;
    in_vs1    = 5'd4;
    in_vs2    = 5'd20;
  endtask

  task automatic send(input logic [2:0] sew, input logic [1:0] lmul,
                      input int vl, input int vstart, input logic [4:0] vd);
    present(sew, lmul, vl, vstart, vd);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({uop_valid, done, illegal, uop_first, uop_last, uop_vd, uop_vs1, uop_vs2,
         uop_vsew, uop_start, uop_len} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b done=%b ill=%b vd=%0d len=%0d, want all 0",
               uop_valid, done, illegal, uop_vd, uop_len);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int evd[3] = '{8, 9, 10};
    int eln[3] = '{4, 4, 2};
    send(3'd2, 2'd2, 10, 0, 5'd8);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (uop_valid !== 1'b1 || uop_vd !== 5'(evd[k]) || uop_start !== '0 ||
          uop_len !== LEN_W'(eln[k]) || uop_first !== (k == 0) || uop_last !== (k == 2) ||
          uop_vs1 !== 5'(4 + k) || uop_vs2 !== 5'(20 + k) || uop_vsew !== 3'd2) begin
        errors++;
        $display("FAIL basic_uop%0d: got v=%b vd=%0d vs1=%0d vs2=%0d st=%0d len=%0d f=%b l=%b sew=%0d, want vd=%0d vs1=%0d vs2=%0d st=0 len=%0d f=%b l=%b sew=2",
                 k, uop_valid, uop_vd, uop_vs1, uop_vs2, uop_start, uop_len, uop_first,
                 uop_last, uop_vsew, evd[k], 4 + k, 20 + k, eln[k], k == 0, k == 2);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || uop_valid !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b valid=%b ill=%b, want done=1 valid=0 ill=0",
               done, uop_valid, illegal);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_vstart();
    int evd[2] = '{9, 10};
    int est[2] = '{1, 0};
    int eln[2] = '{4, 2};
    send(3'd2, 2'd2, 10, 5, 5'd8);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (uop_valid !== 1'b1 || uop_vd !== 5'(evd[k]) || uop_start !== LEN_W'(est[k]) ||
          uop_len !== LEN_W'(eln[k]) || uop_first !== (k == 0) || uop_last !== (k == 1)) begin
        errors++;
        $display("FAIL vstart_uop%0d: got v=%b vd=%0d st=%0d len=%0d f=%b l=%b, want vd=%0d st=%0d len=%0d f=%b l=%b",
                 k, uop_valid, uop_vd, uop_start, uop_len, uop_first, uop_last,
                 evd[k], est[k], eln[k], k == 0, k == 1);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL vstart_done: got done=%b valid=%b, want done=1 valid=0", done, uop_valid);
    end
    tick();
  endtask

  task automatic test_empty();
    send(3'd2, 2'd2, 10, 10, 5'd8);
    checks++;
    if (uop_valid !== 1'b0 || done !== 1'b1 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL empty_vstart: got valid=%b done=%b ill=%b rdy=%b, want 0 1 0 1",
               uop_valid, done, illegal, in_ready);
    end
    send(3'd0, 2'd0, 0, 0, 5'd1);
    checks++;
    if (uop_valid !== 1'b0 || done !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL empty_vl0: got valid=%b done=%b ill=%b, want 0 1 0",
               uop_valid, done, illegal);
    end
    tick();
    checks++;
    if (done !== 1'b0 || uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: got done=%b valid=%b, want 0 0", done, uop_valid);
    end
  endtask

  task automatic test_clamp();
    send(3'd0, 2'd3, 200, 0, 5'd0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (uop_valid !== 1'b1 || uop_vd !== 5'(k) || uop_start !== '0 ||
          uop_len !== LEN_W'(16) || uop_first !== (k == 0) || uop_last !== (k == 7)) begin
        errors++;
        $display("FAIL clamp_uop%0d: got v=%b vd=%0d st=%0d len=%0d f=%b l=%b, want vd=%0d st=0 len=16 f=%b l=%b",
                 k, uop_valid, uop_vd, uop_start, uop_len, uop_first, uop_last,
                 k, k == 0, k == 7);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL clamp_done: got done=%b valid=%b, want done=1 valid=0", done, uop_valid);
    end
    tick();
  endtask

  task automatic test_stall();
    send(3'd2, 2'd2, 10, 0, 5'd8);
    tick();
    uop_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) uop_ready = 1'b1;
      checks++;
      if (uop_valid !== 1'b1 || uop_vd !== 5'd9 || uop_start !== '0 || uop_len !== LEN_W'(4) ||
          uop_first !== 1'b0 || uop_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b vd=%0d st=%0d len=%0d f=%b l=%b, want v=1 vd=9 st=0 len=4 f=0 l=0",
                 c, uop_valid, uop_vd, uop_start, uop_len, uop_first, uop_last);
      end
      if (c < 3) tick();
    end
    tick();
    checks++;
    if (uop_valid !== 1'b1 || uop_vd !== 5'd10 || uop_len !== LEN_W'(2) || uop_last !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume: got v=%b vd=%0d len=%0d l=%b, want v=1 vd=10 len=2 l=1",
               uop_valid, uop_vd, uop_len, uop_last);
    end
    tick();
    checks++;
    if (done !== 1'b1 || uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got done=%b valid=%b, want done=1 valid=0", done, uop_valid);
    end
    tick();
  endtask

  task automatic test_illegal();
    for (int s = 5; s < 8; s++) begin
      send(3'(s), 2'd0, 4, 0, 5'd2);
      checks++;
      if ({done, illegal, uop_valid, in_ready} !== 4'b1101) begin
        errors++;
        $display("FAIL illegal_sew%0d: got done=%b ill=%b valid=%b rdy=%b, want 1 1 0 1",
                 s, done, illegal, uop_valid, in_ready);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse: got done=%b ill=%b, want 0 0", done, illegal);
    end
  endtask

  task automatic test_flush();
    send(3'd2, 2'd2, 16, 0, 5'd0);
    tick();
    present(3'd2, 2'd0, 4, 0, 5'd7);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (uop_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle%0d: got valid=%b done=%b, want 0 0", c, uop_valid, done);
      end
      tick();
    end
    send(3'd3, 2'd0, 2, 0, 5'd3);
    checks++;
    if (uop_valid !== 1'b1 || uop_vd !== 5'd3 || uop_start !== '0 || uop_len !== LEN_W'(2) ||
        uop_first !== 1'b1 || uop_last !== 1'b1 || uop_vsew !== 3'd3) begin
      errors++;
      $display("FAIL flush_new: got v=%b vd=%0d st=%0d len=%0d f=%b l=%b sew=%0d, want v=1 vd=3 st=0 len=2 f=1 l=1 sew=3",
               uop_valid, uop_vd, uop_start, uop_len, uop_first, uop_last, uop_vsew);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL flush_new_done: got done=%b, want 1", done);
    end
    tick();
  endtask

  task automatic test_reset_wrap();
    int evd[4] = '{30, 31, 0, 1};
    send(3'd2, 2'd2, 16, 0, 5'd30);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({uop_valid, done, illegal, uop_first, uop_last, uop_vd, uop_start, uop_len,
         uop_vsew} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b done=%b vd=%0d len=%0d rdy=%b, want 0 0 0 0 1",
               uop_valid, done, uop_vd, uop_len, in_ready);
    end
    send(3'd2, 2'd2, 16, 0, 5'd30);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (uop_valid !== 1'b1 || uop_vd !== 5'(evd[k]) || uop_len !== LEN_W'(4) ||
          uop_first !== (k == 0) || uop_last !== (k == 3)) begin
        errors++;
        $display("FAIL wrap_uop%0d: got v=%b vd=%0d len=%0d f=%b l=%b, want vd=%0d len=4 f=%b l=%b",
                 k, uop_valid, uop_vd, uop_len, uop_first, uop_last, evd[k], k == 0, k == 3);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_done: got done=%b, want 1", done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    send(3'd2, 2'd0, 4, 0, 5'd5);
    tick();
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done_ready: got done=%b rdy=%b, want 1 1", done, in_ready);
    end
    send(3'd2, 2'd0, 3, 0, 5'd6);
    checks++;
    if (uop_valid !== 1'b1 || uop_vd !== 5'd6 || uop_len !== LEN_W'(3) ||
        uop_first !== 1'b1 || uop_last !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got v=%b vd=%0d len=%0d f=%b l=%b, want v=1 vd=6 len=3 f=1 l=1",
               uop_valid, uop_vd, uop_len, uop_first, uop_last);
    end
    tick();
    checks++;
    if (done !== 1'b1 || uop_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done2: got done=%b valid=%b, want 1 0", done, uop_valid);
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    uop_ready = 1'b1;
    in_vsew   = '0;
    in_vlmul  = '0;
    in_vl     = '0;
    in_vstart = '0;
    in_vd     = '0;
    in_vs1    = '0;
    in_vs2    = '0;
    test_reset();
    test_basic();
    test_vstart();
    test_empty();
    test_clamp();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
